// File: rtl/fp16_pkg.sv
// Shared types and constants for the FP16 dot-product sequencer.
package fp16_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MUL,
    S_CAPP,
    S_ADD,
    S_CAPA,
    S_DONE
  } seq_state_t;

  localparam logic FPU_OP_MUL = 1'b1;
  localparam logic FPU_OP_ADD = 1'b0;

  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_ONE  = 16'h3C00;

endpackage

// File: rtl/fp16_dot_sequencer.sv
// Sequences an FP16 dot product of length len onto one shared FPU (mul, then accumulate add).
// Build option FP_DOT_BIAS_EN: adds a bias input that seeds the accumulator.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | in_ready high, waiting for an operand pair
// MUL   | issue a*b to the FPU
// CAPP  | product returns; first element becomes acc directly (no bias)
// ADD   | issue prod+acc to the FPU
// CAPA  | sum returns into acc
// DONE  | out_valid high, holding result until out_ready
module fp16_dot_sequencer
  import fp16_pkg::*;
#(
  parameter int LEN_W      = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
`ifdef FP_DOT_BIAS_EN
  input  logic [DATA_WIDTH-1:0] bias,
`endif
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  fpu_en,
  output logic                  fpu_dec,
  output logic [DATA_WIDTH-1:0] fpu_a,
  output logic [DATA_WIDTH-1:0] fpu_b,
  input  logic [DATA_WIDTH-1:0] fpu_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  seq_state_t            state, state_d;
  logic [LEN_W-1:0]      count, count_d;
  logic [DATA_WIDTH-1:0] acc, acc_d;
  logic [DATA_WIDTH-1:0] fpu_a_q, fpu_a_d;
  logic [DATA_WIDTH-1:0] fpu_b_q, fpu_b_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [DATA_WIDTH-1:0] acc_seed;
  logic                  last;

`ifdef FP_DOT_BIAS_EN
  assign acc_seed = bias;
`else
  logic first, first_d;
  assign acc_seed = DATA_WIDTH'(FP16_ZERO);
`endif

  assign last = (count == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      count      <= '0;
      acc        <= '0;
      fpu_a_q    <= '0;
      fpu_b_q    <= '0;
      out_data_q <= '0;
`ifndef FP_DOT_BIAS_EN
      first      <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      count      <= count_d;
      acc        <= acc_d;
      fpu_a_q    <= fpu_a_d;
      fpu_b_q    <= fpu_b_d;
      out_data_q <= out_data_d;
`ifndef FP_DOT_BIAS_EN
      first      <= first_d;
`endif
    end
  end

  always_comb begin
    state_d    = state;
    count_d    = count;
    acc_d      = acc;
    fpu_a_d    = fpu_a_q;
    fpu_b_d    = fpu_b_q;
    out_data_d = out_data_q;
`ifndef FP_DOT_BIAS_EN
    first_d    = first;
`endif
    busy      = (state != S_IDLE);
    in_ready  = 1'b0;
    fpu_en    = 1'b0;
    fpu_dec   = FPU_OP_ADD;
    out_valid = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          acc_d = acc_seed;
          if (len == '0) begin
            out_data_d = acc_seed;
            state_d    = S_DONE;
          end else begin
            count_d = len;
`ifndef FP_DOT_BIAS_EN
            first_d = 1'b1;
`endif
            state_d = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        in_ready = 1'b1;
        if (in_valid) begin
          fpu_a_d = in_a;
          fpu_b_d = in_b;
          state_d = S_MUL;
        end
      end

      S_MUL: begin
        fpu_en  = 1'b1;
        fpu_dec = FPU_OP_MUL;
        state_d = S_CAPP;
      end

      S_CAPP: begin
`ifndef FP_DOT_BIAS_EN
        // First product seeds acc directly instead of adding it to zero.
        if (first) begin
          acc_d   = fpu_result;
          first_d = 1'b0;
          count_d = count - LEN_W'(1);
          if (last) begin
            out_data_d = fpu_result;
            state_d    = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end else
`endif
        begin
          fpu_a_d = fpu_result;
          fpu_b_d = acc;
          state_d = S_ADD;
        end
      end

      S_ADD: begin
        fpu_en  = 1'b1;
        fpu_dec = FPU_OP_ADD;
        state_d = S_CAPA;
      end

      S_CAPA: begin
        acc_d   = fpu_result;
        count_d = count - LEN_W'(1);
        if (last) begin
          out_data_d = fpu_result;
          state_d    = S_DONE;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign fpu_a    = fpu_a_q;
  assign fpu_b    = fpu_b_q;
  assign out_data = out_data_q;

endmodule

// File: tb/tb_fp16_dot_sequencer.sv
// Bench for fp16_dot_sequencer: behavioural FPU plus real-valued dot-product reference.
module tb_fp16_dot_sequencer;

`ifdef FP_DOT_BIAS_EN
  localparam bit BIAS = 1'b1;
`else
  localparam bit BIAS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  len;
  logic [15:0] bias_v;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        fpu_en;
  logic        fpu_dec;
  logic [15:0] fpu_a;
  logic [15:0] fpu_b;
  logic [15:0] fpu_result;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  logic [32:0] iss_log[$];
  logic [15:0] va[16];
  logic [15:0] vb[16];
  logic [15:0] pool[8] = '{16'h3800, 16'h3C00, 16'h3E00, 16'h4000,
                           16'h4200, 16'hBC00, 16'hC000, 16'hB800};

  fp16_dot_sequencer #(.LEN_W(8), .DATA_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len        (len),
`ifdef FP_DOT_BIAS_EN
    .bias       (bias_v),
`endif
    .busy       (busy),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .fpu_en     (fpu_en),
    .fpu_dec    (fpu_dec),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_result (fpu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  // Exact FP16 <-> real conversion; stimulus keeps every value exactly representable.
  function automatic real h2r(input logic [15:0] h);
    int  e;
    real r;
    e = int'(h[14:10]);
    r = (e == 0) ? real'(int'(h[9:0])) / 1024.0 : 1.0 + real'(int'(h[9:0])) / 1024.0;
    if (e == 0) e = 1;
    for (int k = 0; k < 40 && e > 15; k++) begin r = r * 2.0; e--; end
    for (int k = 0; k < 40 && e < 15; k++) begin r = r / 2.0; e++; end
    return h[15] ? -r : r;
  endfunction

  function automatic logic [15:0] r2h(input real x);
    real m;
    int  e;
    logic s;
    if (x == 0.0) return 16'h0000;
    s = (x < 0.0);
    m = s ? -x : x;
    e = 15;
    for (int k = 0; k < 40 && m >= 2.0; k++) begin m = m / 2.0; e++; end
    for (int k = 0; k < 40 && m < 1.0; k++) begin m = m * 2.0; e--; end
    return {s, 5'(e), 10'($rtoi((m - 1.0) * 1024.0 + 0.5))};
  endfunction

  // Behavioural FPU: one op per fpu_en, result registered for the next cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fpu_en) begin
      iss_log.push_back({fpu_dec, fpu_a, fpu_b});
      fpu_result <= fpu_dec ? r2h(h2r(fpu_a) * h2r(fpu_b)) : r2h(h2r(fpu_a) + h2r(fpu_b));
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_in_ready"}, in_ready, 0);
    check_val({tag, "_fpu_en"}, fpu_en, 0);
    check_val({tag, "_fpu_dec"}, fpu_dec, 0);
    check_val({tag, "_out_valid"}, out_valid, 0);
    check_val({tag, "_fpu_ab"}, {fpu_a, fpu_b}, 0);
    check_val({tag, "_out_data"}, out_data, 0);
  endtask

  // Runs one job on va/vb[0..n-1]; stalls 4 cycles before element stall_at; holds DONE for hold cycles.
  task automatic run_job(input int n, input int stall_at, input int hold, output logic [15:0] got);
    logic [32:0] exp_iss[$];
    real         acc_m, p;
    logic [15:0] exp_out;
    int          c0, idx, waits, stall_left, lat_exp;
    logic        ready_prev, seen;

    exp_iss.delete();
    acc_m = h2r(bias_v);
    for (int i = 0; i < n; i++) begin
      p = h2r(va[i]) * h2r(vb[i]);
      exp_iss.push_back({1'b1, va[i], vb[i]});
      if (i > 0 || BIAS) exp_iss.push_back({1'b0, r2h(p), r2h(acc_m)});
      acc_m = acc_m + p;
    end
    exp_out = r2h(acc_m);
    lat_exp = (n == 0) ? 0 : (BIAS ? 5 * n : 5 * n - 2);

    iss_log.delete();
    @(negedge clk);
    start = 1'b1; len = 8'(n); in_valid = 1'b0;
    c0 = cyc; idx = 0; waits = 0; stall_left = 4; ready_prev = 1'b0; seen = 1'b0; got = '0;
    for (int t = 0; t < 2000 && !seen; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (in_valid && ready_prev) idx++;
      if (out_valid) begin
        seen = 1'b1;
        in_valid = 1'b0;
      end else begin
        if (idx == stall_at && stall_left > 0 && (in_ready || stall_left < 4)) begin
          if (stall_left < 4) check_val("stall_in_ready", in_ready, 1);
          check_val("stall_no_issue", fpu_en, 0);
          in_valid = 1'b0;
          stall_left--;
        end else begin
          in_valid = (idx < n);
          in_a = va[idx % 16];
          in_b = vb[idx % 16];
        end
        if (in_ready && !in_valid) waits++;
        ready_prev = in_ready;
      end
    end
    if (!seen) begin
      check_val("out_valid_timeout", out_valid, 1);
      return;
    end
    got = out_data;
    check_val("latency", cyc - c0 - 1, lat_exp + waits);
    check_val("out_data", out_data, exp_out);
    check_val("busy_done", busy, 1);

    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      start = 1'b1; len = 8'd3;
      @(negedge clk);
      check_val("hold_valid", out_valid, 1);
      check_val("hold_data", out_data, exp_out);
      check_val("hold_busy", busy, 1);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val("post_hs_valid", out_valid, 0);
    check_val("post_hs_busy", busy, 0);
    check_val("n_issue", iss_log.size(), exp_iss.size());
    for (int i = 0; i < exp_iss.size() && i < iss_log.size(); i++)
      check_val($sformatf("issue%0d", i), iss_log[i], exp_iss[i]);
  endtask

  logic [15:0] res;
  int          n;

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; bias_v = 16'h0000;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;

    va[0] = 16'h3C00; vb[0] = 16'h4000; va[1] = 16'h4000; vb[1] = 16'h4200;
    run_job(2, -1, 0, res);
    check_val("plan_len2", res, 16'h4800);

    run_job(0, -1, 0, res);
    check_val("plan_len0", res, 16'h0000);

    va[0] = 16'h3C00; vb[0] = 16'h3C00; va[1] = 16'h4000; vb[1] = 16'h4000;
    va[2] = 16'h3800; vb[2] = 16'h4000;
    run_job(3, 2, 0, res);
    check_val("plan_stall", res, 16'h4600);

    run_job(2, -1, 5, res);

    // Reset while an add is in flight: job must vanish without output.
    @(negedge clk);
    start = 1'b1; len = 8'd4; in_valid = 1'b1; in_a = 16'h4000; in_b = 16'h3C00;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (fpu_en && !fpu_dec) break;
    end
    check_val("reached_add", {fpu_en, fpu_dec}, 2'b10);
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check_idle("midjob_reset");
    reset = 1'b0;
    @(negedge clk);
    check_val("after_reset_busy", busy, 0);
    check_val("after_reset_valid", out_valid, 0);
    va[0] = 16'h4200; vb[0] = 16'h4200;
    run_job(1, -1, 0, res);
    check_val("plan_after_reset", res, 16'h4880);

`ifdef FP_DOT_BIAS_EN
    bias_v = 16'h3C00;
    va[0] = 16'h4000; vb[0] = 16'h4000;
    run_job(1, -1, 0, res);
    check_val("plan_bias", res, 16'h4500);
    check_val("bias_add_b", iss_log.size() > 1 ? iss_log[1][15:0] : 16'hFFFF, 16'h3C00);
    run_job(0, -1, 0, res);
    check_val("bias_len0", res, 16'h3C00);
`endif

    for (int j = 0; j < 12; j++) begin
      n = $urandom_range(0, 8);
      for (int i = 0; i < n; i++) begin
        va[i] = pool[$urandom_range(0, 7)];
        vb[i] = pool[$urandom_range(0, 7)];
      end
      bias_v = BIAS ? pool[$urandom_range(0, 7)] : 16'h0000;
      run_job(n, $urandom_range(0, 1) ? int'($urandom_range(0, 8)) : -1,
              $urandom_range(0, 3), res);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fp16_dot_sequencer.md
Name: fp16_dot_sequencer

Overview:
- Controller that computes an FP16 dot product of length N on a single shared `Floating_point_Unit` (one op per issue, 1-cycle registered result).
- Accepts operand pairs on a valid/ready stream.
- Issues a multiply (dec=1) for each pair, then an accumulate add (dec=0), and returns the final sum on an output handshake.
- Sits between the TPU operand fetch and the FPU instance, and owns that FPU exclusively.

Parameters:
- LEN_W, 8, width of the vector-length input (max N = 2^LEN_W-1).
- DATA_WIDTH, 16, FP16 word width; must match the FPU.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; launches a job when idle
- len  in  LEN_W  element count N, sampled on accepted start
- busy  out  1  high from accepted start until result handshake completes
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer accepts pair this cycle
- in_a  in  DATA_WIDTH  activation operand
- in_b  in  DATA_WIDTH  weight operand
- fpu_en  out  1  FPU issue strobe
- fpu_dec  out  1  FPU op select: 1 = multiply, 0 = add
- fpu_a  out  DATA_WIDTH  FPU operand a
- fpu_b  out  DATA_WIDTH  FPU operand b
- fpu_result  in  DATA_WIDTH  FPU registered result; valid the cycle after fpu_en
- out_valid  out  1  dot-product result valid
- out_ready  in  1  consumer accepts result
- out_data  out  DATA_WIDTH  dot-product result

Behaviour:
- Reset (sync, active-high) overrides everything, including mid-job:
  - state=IDLE; busy, in_ready, fpu_en, fpu_dec, out_valid = 0.
  - fpu_a, fpu_b, out_data, acc, remaining count = 0.
  - Any in-flight job is abandoned; no output is produced.
- FSM states: IDLE, FETCH, MUL, CAPP, ADD, CAPA, DONE.
- IDLE:
  - start=1 with len>0: latch count=len, first=1, go to FETCH, busy=1.
  - start=1 with len=0: out_data=0x0000, go to DONE.
  - start while busy is ignored.
- FETCH:
  - in_ready=1. On in_valid, latch in_a/in_b and go to MUL.
  - in_ready is high only in FETCH.
- MUL: fpu_en=1, fpu_dec=1, fpu_a=a, fpu_b=b; go to CAPP.
- CAPP: capture fpu_result into prod.
  - If first: acc=prod, first=0, skip the add.
  - Else go to ADD.
  - Decrement count when the add is skipped or after CAPA.
- ADD: fpu_en=1, fpu_dec=0, fpu_a=prod, fpu_b=acc; go to CAPA.
- CAPA: acc=fpu_result.
- Loop exit: after CAPP (first element) or CAPA, if count==0 go to DONE, else FETCH.
- DONE:
  - out_valid=1, out_data=acc; hold stable until out_ready.
  - On handshake: out_valid=0, busy=0, go to IDLE.
- fpu_en is 0 in every state not listed above; fpu_a/fpu_b hold their last values.
- Latency per element: 3 cycles for the first, 5 for each subsequent one, plus in_valid wait.
- Total for N elements with in_valid held high: 5N-2 cycles from start to out_valid.
- Arithmetic: all FP16 math is delegated to the FPU. The sequencer never modifies values. The accumulate order is fixed as ((p0+p1)+p2)+…
- Skipping the add on the first element avoids an add-with-zero issue to the FPU.

Optional Feature:
- Macro FP_DOT_BIAS_EN.
- Defined:
  - Adds input port `bias` [DATA_WIDTH-1:0], sampled on accepted start.
  - The first element is not skipped: it goes CAPP→ADD with fpu_b=bias. Result = bias + Σ a_i·b_i.
  - len=0 yields out_data=bias.
- Undefined: no bias port; behaviour exactly as above.

Decomposition:
- Package fp16_pkg:
  - FSM state enum `seq_state_t`.
  - Constants FPU_OP_MUL=1, FPU_OP_ADD=0.
  - FP16 constants FP16_ZERO=0x0000, FP16_ONE=0x3C00.
- No sub-module needed; single module with one FSM plus datapath registers (a, b, prod, acc, count).

Test Plan:
- len=2, pairs (0x3C00,0x4000),(0x4000,0x4200) → fpu_dec sequence 1,1,0; out_data=0x4800 (8.0) asserted 8 cycles after start.
- len=0 start → out_valid next cycle, out_data=0x0000, no fpu_en pulses.
- len=3 with in_valid deasserted 4 cycles before element 2 → in_ready held, no FPU issue during the stall; result (1·1+2·2+0.5·2)=0x4600 (6.0).
- out_ready held low 5 cycles in DONE → out_valid and out_data stable; second start ignored; busy stays 1.
- reset asserted in ADD state of a len=4 job → next cycle all outputs 0, state IDLE; fresh len=1 job (0x4200,0x4200) → 0x4880 (9.0).
- FP_DOT_BIAS_EN defined: bias=0x3C00, len=1 pair (0x4000,0x4000) → ADD issued with fpu_b=0x3C00; out_data=0x4500 (5.0).
